sweep_ctrl: RTL and testbench
=============================

Name: sweep_ctrl

Overview:
- Control stage directly upstream of up_down_counter. It drives the counter's en_b, load_b, up and load_in, and reads back q.
- It sequences bounded sweeps between a low and a high value: single up, single down, or ping-pong for a programmed number of legs.
- Counter contract this block relies on:
  - load_b=0 loads load_in at clk rise, with priority over counting.
  - en_b=0 with load_b=1 counts one step per clk in direction up.

Parameters:
N, 4, counter width; must equal the driven up_down_counter's N.
S, 8, width of leg-count field and leg counter.

Ports:
clk  in  1  system clock, rising edge.
rst  in  1  synchronous reset, active-high.
start  in  1  one-cycle request; sampled in IDLE only.
stop  in  1  abort request; sampled in any non-IDLE state.
mode  in  2  00 up-once, 01 down-once, 10 ping-pong (starts upward), 11 reserved (treated as error).
lo_val  in  N  lower sweep bound.
hi_val  in  N  upper sweep bound.
num_legs  in  S  ping-pong leg count; 0 = run until stop.
q  in  N  counter output, fed back.
en_b  out  1  counter enable, active-low.
load_b  out  1  counter load, active-low.
up  out  1  counter direction, 1 = up.
load_in  out  N  counter load value.
busy  out  1  high in every state except IDLE.
done  out  1  one-cycle pulse on completion, abort or error.
aborted  out  1  valid with done; 1 = ended by stop.
err  out  1  valid with done; 1 = lo_val>hi_val or mode=11.
legs_done  out  S  completed legs of the current or last run.

Behaviour:
- Reset values: state=IDLE, en_b=1, load_b=1, up=1, load_in=0, busy=0, done=0, aborted=0, err=0, legs_done=0. Latched bounds/mode/num_legs are cleared to 0.
- Latching: at the start edge in IDLE, lo_val, hi_val, mode and num_legs are latched; later input changes are ignored until the next run.
- States: IDLE, LOAD, RUN, TURN, FIN.
- IDLE:
  - en_b=1, load_b=1.
  - start=1 with a bad config (lo>hi or mode=11) -> FIN with err=1.
  - start=1 with a valid config -> LOAD, legs_done cleared to 0.
- LOAD (1 cycle):
  - load_b=0, en_b=1.
  - up=1 and load_in=lo for mode 00/10; up=0 and load_in=hi for mode 01.
  - -> RUN.
- RUN:
  - load_b=1. Leg end value = hi if up, else lo.
  - en_b is Mealy: en_b = (q == end), so the counter freezes in the cycle it reaches end and never overshoots.
  - When q==end, legs_done increments.
  - Exit from q==end: mode 00/01 -> FIN. Mode 10 -> TURN, unless num_legs!=0 and the incremented legs_done equals num_legs, in which case -> FIN.
- TURN (1 cycle): en_b=1, load_b=1, up toggles (registered), -> RUN.
- FIN (1 cycle): done=1 with aborted/err; en_b=1, load_b=1; -> IDLE.
- Output registration: up and load_in are registered and hold their last values in IDLE.
- stop: in LOAD, RUN or TURN, stop=1 -> FIN with aborted=1. en_b is forced to 1 in that same cycle (Mealy), so the counter does not step. stop has priority over a leg end in the same cycle.
- Stale-q guard: the RUN end compare is ignored in the first RUN cycle after TURN. q still equals the previous end value in that cycle and must not terminate the new leg.
- lo==hi: LOAD, then one RUN cycle with q==end; mode 10 behaves as if each leg has zero length (legs_done still counts).
- Leg counter: legs_done saturates at 2^S-1 when num_legs=0; the sweep continues.
- Mid-operation reset: rst returns to IDLE at the next edge with all outputs at reset values; no done pulse.
- Timing from start edge t0: LOAD at t0+1; RUN with q=lo..hi over cycles t0+2..t0+2+(hi-lo); FIN one cycle later.

Test Plan:
1. N=4, mode=00, lo=2, hi=5, start -> load_b=0 in one cycle with load_in=2; q steps 2,3,4,5; en_b=1 while q=5; done=1 one cycle later with err=0; legs_done=1.
2. mode=01, lo=0, hi=15 -> load_in=15, up=0; q counts 15 down to 0, freezes at 0; done pulse; no wrap to 15 observed.
3. mode=10, lo=3, hi=6, num_legs=3 -> q sequence 3..6, hold, 6..3, hold, 3..6; up toggles twice; done with legs_done=3.
4. mode=10, num_legs=0, stop asserted while q=4 counting up -> en_b=1 that cycle, q holds 4; done=1, aborted=1.
5. lo=9, hi=4, start -> no load_b pulse; done=1, err=1 within 2 cycles. Then mode=11 with valid bounds -> same error response.
6. rst asserted mid-RUN -> next cycle busy=0, en_b=1, load_b=1, up=1, legs_done=0, no done. Then start asserted together with stop in IDLE -> run begins normally, because stop is ignored in IDLE.

Source files
------------

// File: rtl/sweep_if.sv
// Handshake bundle between the sweep controller, its requester and the
// up/down counter it drives.
interface sweep_if #(
  parameter int N = 4,
  parameter int S = 8
);
  logic         start;
  logic         stop;
  logic [1:0]   mode;
  logic [N-1:0] lo_val;
  logic [N-1:0] hi_val;
  logic [S-1:0] num_legs;
  logic [N-1:0] q;
  logic         en_b;
  logic         load_b;
  logic         up;
  logic [N-1:0] load_in;
  logic         busy;
  logic         done;
  logic         aborted;
  logic         err;
  logic [S-1:0] legs_done;

  modport master (
    output start, stop, mode, lo_val, hi_val, num_legs, q,
    input  en_b, load_b, up, load_in, busy, done, aborted, err, legs_done
  );

  modport slave (
    input  start, stop, mode, lo_val, hi_val, num_legs, q,
    output en_b, load_b, up, load_in, busy, done, aborted, err, legs_done
  );
endinterface

// File: rtl/sweep_ctrl.sv
// Sequences bounded up, down or ping-pong sweeps on an external up/down
// counter by driving its load/enable/direction and watching its q output.
module sweep_ctrl #(
  parameter int N = 4,
  parameter int S = 8
) (
  input  logic    clk,
  input  logic    rst,
  sweep_if.slave  bus
);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    LOAD = 3'd1,
    RUN  = 3'd2,
    TURN = 3'd3,
    FIN  = 3'd4
  } state_t;

  localparam logic [1:0] MODE_UP   = 2'b00;
  localparam logic [1:0] MODE_DOWN = 2'b01;
  localparam logic [1:0] MODE_PP   = 2'b10;
  localparam logic [1:0] MODE_RSV  = 2'b11;

  state_t       state_q, state_d;
  logic [1:0]   mode_q, mode_d;
  logic [N-1:0] lo_q, lo_d;
  logic [N-1:0] hi_q, hi_d;
  logic [S-1:0] num_q, num_d;
  logic [S-1:0] legs_q, legs_d;
  logic         up_q, up_d;
  logic [N-1:0] load_in_q, load_in_d;
  logic         busy_q, busy_d;
  logic         done_q, done_d;
  logic         aborted_q, aborted_d;
  logic         err_q, err_d;
  logic         fresh_q, fresh_d;

  logic [N-1:0] end_val;
  logic         guard;
  logic         at_end;
  logic         stop_act;
  logic         cfg_bad;
  logic         last_leg;
  logic [S-1:0] legs_inc;

  // Leg-end detection; q is stale for one cycle after a turn, except when
  // lo==hi where the stale value is also the genuine new end.
  always_comb begin
    end_val  = up_q ? hi_q : lo_q;
    guard    = fresh_q && (lo_q != hi_q);
    at_end   = (state_q == RUN) && !guard && (bus.q == end_val);
    stop_act = bus.stop && ((state_q == LOAD) || (state_q == RUN) || (state_q == TURN));
    cfg_bad  = (bus.lo_val > bus.hi_val) || (bus.mode == MODE_RSV);
    legs_inc = (legs_q == {S{1'b1}}) ? legs_q : legs_q + 1'b1;
    last_leg = (mode_q != MODE_PP) ||
               ((num_q != {S{1'b0}}) && (legs_inc == num_q));
  end

  assign bus.en_b      = !((state_q == RUN) && !bus.stop && !at_end);
  assign bus.load_b    = (state_q != LOAD);
  assign bus.up        = up_q;
  assign bus.load_in   = load_in_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.aborted   = aborted_q;
  assign bus.err       = err_q;
  assign bus.legs_done = legs_q;

  always_comb begin
    state_d   = state_q;
    mode_d    = mode_q;
    lo_d      = lo_q;
    hi_d      = hi_q;
    num_d     = num_q;
    legs_d    = legs_q;
    up_d      = up_q;
    load_in_d = load_in_q;
    done_d    = 1'b0;
    aborted_d = aborted_q;
    err_d     = err_q;
    fresh_d   = 1'b0;

    case (state_q)
      IDLE: begin
        if (bus.start) begin
          mode_d    = bus.mode;
          lo_d      = bus.lo_val;
          hi_d      = bus.hi_val;
          num_d     = bus.num_legs;
          aborted_d = 1'b0;
          if (cfg_bad) begin
            state_d = FIN;
            err_d   = 1'b1;
            done_d  = 1'b1;
          end else begin
            state_d   = LOAD;
            err_d     = 1'b0;
            legs_d    = '0;
            up_d      = (bus.mode != MODE_DOWN);
            load_in_d = (bus.mode == MODE_DOWN) ? bus.hi_val : bus.lo_val;
          end
        end
      end
      LOAD: begin
        if (stop_act) begin
          state_d   = FIN;
          aborted_d = 1'b1;
          done_d    = 1'b1;
        end else begin
          state_d = RUN;
        end
      end
      RUN: begin
        if (stop_act) begin
          state_d   = FIN;
          aborted_d = 1'b1;
          done_d    = 1'b1;
        end else if (at_end) begin
          legs_d = legs_inc;
          if (last_leg) begin
            state_d = FIN;
            done_d  = 1'b1;
          end else begin
            state_d = TURN;
            up_d    = !up_q;
          end
        end
      end
      TURN: begin
        if (stop_act) begin
          state_d   = FIN;
          aborted_d = 1'b1;
          done_d    = 1'b1;
        end else begin
          state_d = RUN;
          fresh_d = 1'b1;
        end
      end
      FIN:     state_d = IDLE;
      default: state_d = IDLE;
    endcase

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      mode_q    <= '0;
      lo_q      <= '0;
      hi_q      <= '0;
      num_q     <= '0;
      legs_q    <= '0;
      up_q      <= 1'b1;
      load_in_q <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      aborted_q <= 1'b0;
      err_q     <= 1'b0;
      fresh_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      mode_q    <= mode_d;
      lo_q      <= lo_d;
      hi_q      <= hi_d;
      num_q     <= num_d;
      legs_q    <= legs_d;
      up_q      <= up_d;
      load_in_q <= load_in_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      aborted_q <= aborted_d;
      err_q     <= err_d;
      fresh_q   <= fresh_d;
    end
  end

endmodule

// File: tb/tb_sweep_ctrl.sv
// Bench for sweep_ctrl: a behavioural up/down counter closes the loop and an
// arithmetic trace model predicts q per cycle for each sweep.
module tb_sweep_ctrl;

  localparam int N = 4;
  localparam int S = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [N-1:0] q_cnt = '0;
  int total = 0;
  int bad   = 0;

  sweep_if #(.N(N), .S(S)) bus ();

  sweep_ctrl #(.N(N), .S(S)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  // Counter being steered: load has priority, otherwise count when enabled.
  always_ff @(posedge clk) begin
    if (!bus.load_b)    q_cnt <= bus.load_in;
    else if (!bus.en_b) q_cnt <= bus.up ? q_cnt + 1'b1 : q_cnt - 1'b1;
  end
  assign bus.q = q_cnt;

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, got, exp);
    end
  endtask

  // Appends every value visited when walking from a to b by unit steps.
  task automatic walk(inout int tr[$], input int a, input int b);
    int v;
    v = a;
    tr.push_back(v);
    while (v != b) begin
      v = (b > v) ? v + 1 : v - 1;
      tr.push_back(v);
    end
  endtask

  task automatic run_check(input int lo, input int hi, input int md, input int nl,
                           input bit with_stop);
    int tr[$];
    int legs_exp;
    int cur_end;
    int prev_end;
    bit dir_up;
    dir_up  = (md != 1);
    cur_end = dir_up ? hi : lo;
    walk(tr, dir_up ? lo : hi, cur_end);
    legs_exp = (md == 2) ? nl : 1;
    for (int k = 2; k <= legs_exp; k++) begin
      prev_end = cur_end;
      dir_up   = !dir_up;
      cur_end  = dir_up ? hi : lo;
      tr.push_back(prev_end);
      walk(tr, prev_end, cur_end);
    end

    bus.start    = 1'b1;
    bus.stop     = with_stop;
    bus.mode     = 2'(md);
    bus.lo_val   = 4'(lo);
    bus.hi_val   = 4'(hi);
    bus.num_legs = 8'(nl);
    step();
    bus.start    = 1'b0;
    bus.stop     = 1'b0;
    bus.lo_val   = 4'($urandom);
    bus.hi_val   = 4'($urandom);
    bus.mode     = 2'($urandom_range(0, 3));
    bus.num_legs = 8'($urandom);
    chk("load_b", 32'(bus.load_b), 0);
    chk("load_in", 32'(bus.load_in), (md == 1) ? hi : lo);
    chk("load_up", 32'(bus.up), (md != 1) ? 1 : 0);
    chk("load_busy", 32'(bus.busy), 1);
    foreach (tr[i]) begin
      step();
      chk("q_trace", 32'(bus.q), tr[i]);
      chk("done_early", 32'(bus.done), 0);
    end
    step();
    chk("done", 32'(bus.done), 1);
    chk("aborted", 32'(bus.aborted), 0);
    chk("err", 32'(bus.err), 0);
    chk("legs_done", 32'(bus.legs_done), legs_exp);
    chk("q_final", 32'(bus.q), cur_end);
    step();
    chk("done_clr", 32'(bus.done), 0);
    chk("busy_idle", 32'(bus.busy), 0);
  endtask

  initial begin
    int lo, hi, md, nl;
    bus.start = 1'b0; bus.stop = 1'b0; bus.mode = 2'b00;
    bus.lo_val = '0; bus.hi_val = '0; bus.num_legs = '0;

    rst = 1'b1;
    step();
    step();
    chk("rst_busy", 32'(bus.busy), 0);
    chk("rst_en_b", 32'(bus.en_b), 1);
    chk("rst_load_b", 32'(bus.load_b), 1);
    chk("rst_up", 32'(bus.up), 1);
    chk("rst_load_in", 32'(bus.load_in), 0);
    chk("rst_done", 32'(bus.done), 0);
    chk("rst_aborted", 32'(bus.aborted), 0);
    chk("rst_err", 32'(bus.err), 0);
    chk("rst_legs", 32'(bus.legs_done), 0);
    rst = 1'b0;
    step();

    run_check(2, 5, 0, 0, 1'b0);
    run_check(0, 15, 1, 0, 1'b0);
    run_check(3, 6, 2, 3, 1'b0);
    run_check(7, 7, 2, 3, 1'b0);
    run_check(9, 9, 0, 0, 1'b0);

    // Abort while counting up through 4.
    bus.start = 1'b1; bus.mode = 2'b10; bus.lo_val = 4'd3; bus.hi_val = 4'd6;
    bus.num_legs = 8'd0;
    step();
    bus.start = 1'b0;
    step();
    chk("stop_q3", 32'(bus.q), 3);
    step();
    chk("stop_q4", 32'(bus.q), 4);
    chk("stop_en_pre", 32'(bus.en_b), 0);
    bus.stop = 1'b1;
    #1;
    chk("stop_en_b", 32'(bus.en_b), 1);
    step();
    bus.stop = 1'b0;
    chk("stop_q_hold", 32'(bus.q), 4);
    chk("stop_done", 32'(bus.done), 1);
    chk("stop_aborted", 32'(bus.aborted), 1);
    chk("stop_err", 32'(bus.err), 0);
    step();
    chk("stop_idle", 32'(bus.busy), 0);

    // Bad bounds, then reserved mode.
    bus.start = 1'b1; bus.mode = 2'b00; bus.lo_val = 4'd9; bus.hi_val = 4'd4;
    step();
    bus.start = 1'b0;
    chk("bnd_load_b", 32'(bus.load_b), 1);
    chk("bnd_done", 32'(bus.done), 1);
    chk("bnd_err", 32'(bus.err), 1);
    step();
    chk("bnd_done_clr", 32'(bus.done), 0);
    bus.start = 1'b1; bus.mode = 2'b11; bus.lo_val = 4'd1; bus.hi_val = 4'd8;
    step();
    bus.start = 1'b0;
    chk("rsv_load_b", 32'(bus.load_b), 1);
    chk("rsv_done", 32'(bus.done), 1);
    chk("rsv_err", 32'(bus.err), 1);
    chk("rsv_aborted", 32'(bus.aborted), 0);
    step();

    // Reset mid-run after the first turn (direction down, one leg done).
    bus.start = 1'b1; bus.mode = 2'b10; bus.lo_val = 4'd0; bus.hi_val = 4'd2;
    bus.num_legs = 8'd0;
    step();
    bus.start = 1'b0;
    for (int i = 0; i < 5; i++) step();
    chk("mid_up", 32'(bus.up), 0);
    chk("mid_legs", 32'(bus.legs_done), 1);
    chk("mid_busy", 32'(bus.busy), 1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("mrst_busy", 32'(bus.busy), 0);
    chk("mrst_en_b", 32'(bus.en_b), 1);
    chk("mrst_load_b", 32'(bus.load_b), 1);
    chk("mrst_up", 32'(bus.up), 1);
    chk("mrst_legs", 32'(bus.legs_done), 0);
    chk("mrst_done", 32'(bus.done), 0);
    step();
    chk("mrst_done2", 32'(bus.done), 0);

    run_check(1, 4, 0, 0, 1'b1);

    for (int r = 0; r < 20; r++) begin
      lo = $urandom_range(0, 15);
      hi = $urandom_range(lo, 15);
      if ($urandom_range(0, 5) == 0) hi = lo;
      md = $urandom_range(0, 2);
      nl = $urandom_range(1, 4);
      run_check(lo, hi, md, nl, 1'b0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: observed=running expected=finished");
    $fatal(1, "bench timeout");
  end

endmodule
